trit_stream_decoder: RTL and testbench

TRIT_STREAM_DECODER -- requirements
Module: trit_stream_decoder

---
 rtl/ternary_pkg.sv | 19 +
 rtl/trit_mac.sv | 31 +++
 rtl/trit_stream_decoder.sv | 101 ++++++++++
 tb/tb_trit_stream_decoder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ternary_pkg.sv
// rtl/ternary_pkg.sv - shared trit codes and decoder state encoding
//
// Purpose: constants and types shared by trit_mac and trit_stream_decoder.
// Ports:   none (package).
package ternary_pkg;

  // Two-wire trit codes as {t1,t0}.
  localparam logic [1:0] TRIT_0   = 2'b00;
  localparam logic [1:0] TRIT_1   = 2'b01;
  localparam logic [1:0] TRIT_2   = 2'b10;
  localparam logic [1:0] TRIT_BAD = 2'b11;

  // COLLECT gathers trits; HOLD presents a finished or aborted word.
  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/trit_mac.sv
// rtl/trit_mac.sv - combinational acc*3+trit step
//
// Purpose: one base-3 multiply-accumulate step on a two-wire trit code.
// Ports:
//   acc  in  W  running accumulator
//   code in  2  trit code {t1,t0}
//   sum  out W  acc*3+trit, truncated to W bits
//   bad  out 1  code is the illegal TRIT_BAD pattern (sum meaningless then)
module trit_mac
  import ternary_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] acc,
  input  logic [1:0]   code,
  output logic [W-1:0] sum,
  output logic         bad
);

  // Widened by two bits so acc*3+2 never wraps before truncation; with a
  // legal W the top bits are always zero for in-range accumulators.
  function automatic logic [W-1:0] mac3(input logic [W-1:0] a, input logic [1:0] c);
    logic [W+1:0] wide;
    wide = {2'b00, a} + {1'b0, a, 1'b0} + {{W{1'b0}}, c};
    return wide[W-1:0];
  endfunction

  assign sum = mac3(acc, code);
  assign bad = (code == TRIT_BAD);

endmodule

// File: rtl/trit_stream_decoder.sv
// rtl/trit_stream_decoder.sv - serial trit word to binary decoder
//
// Purpose: collects TRITS trits (most significant first) into a binary word
//          and holds the result until the consumer takes it. An illegal trit
//          aborts the word and presents out_data=0 with out_err=1.
// Ports:
//   clk       in  1  rising-edge clock
//   reset     in  1  asynchronous active-high reset
//   in_valid  in  1  trit on in_t1/in_t0 offered
//   in_ready  out 1  trit accepted this cycle (high in COLLECT)
//   in_t1     in  1  trit code high wire
//   in_t0     in  1  trit code low wire
//   out_valid out 1  result presented (high in HOLD)
//   out_ready in  1  consumer takes the result
//   out_data  out W  decoded value
//   out_err   out 1  presented result is an aborted word
module trit_stream_decoder
  import ternary_pkg::*;
#(
  parameter int TRITS = 5,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_t1,
  input  logic         in_t0,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_err
);

  localparam int             CW   = (TRITS > 1) ? $clog2(TRITS) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TRITS - 1);

  state_t        state, state_n;
  logic [W-1:0]  acc;
  logic [W-1:0]  mac_sum;
  logic [CW-1:0] cnt;
  logic          bad;
  logic          accept;

  trit_mac #(.W(W)) u_mac (
    .acc  (acc),
    .code ({in_t1, in_t0}),
    .sum  (mac_sum),
    .bad  (bad)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= COLLECT;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept && (bad || cnt == LAST)) state_n = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        // Handshake cycle leaves in_ready low, so no trit slips in here.
        if (out_ready) state_n = COLLECT;
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else if (accept) begin
      if (bad) begin
        acc      <= '0;
        cnt      <= '0;
        out_data <= '0;
        out_err  <= 1'b1;
      end else if (cnt == LAST) begin
        acc      <= '0;
        cnt      <= '0;
        out_data <= mac_sum;
        out_err  <= 1'b0;
      end else begin
        acc <= mac_sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trit_stream_decoder.sv
// tb/tb_trit_stream_decoder.sv - self-checking bench for trit_stream_decoder
module tb_trit_stream_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       in_t1;
  logic       in_t0;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_err;

  trit_stream_decoder #(.TRITS(5), .W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_t1     (in_t1),
    .in_t0     (in_t0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] codes;  // trit i at codes[9-2*i -: 2]
    int         n;      // trits to drive (aborted words stop early)
    logic [7:0] data;
    logic       err;
    int         gap;    // max idle cycles inserted before each trit
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  vec_t tbl[9];
  exp_t sb[$];
  int   passes = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Drives one word, pushes its expected result, checks one-cycle latency.
  task automatic run_word(input logic [9:0] codes, input int n, input logic [7:0] d,
                          input logic e, input int gap);
    exp_t x;
    x.data = d;
    x.err  = e;
    sb.push_back(x);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap > 0) ? $urandom_range(0, gap) : 0;
      repeat (g) begin
        @(negedge clk);
        in_valid = 1'b0;
        {in_t1, in_t0} = 2'b11;
      end
      @(negedge clk);
      check("early_out_valid", out_valid, 0);
      in_valid = 1'b1;
      {in_t1, in_t0} = codes[9-2*i -: 2];
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("latency_out_valid", out_valid, 1);
  endtask

  // Waits (bounded) for a result, compares against scoreboard, stalls, handshakes.
  task automatic take_result(input int stall, input logic hs_valid, input logic [1:0] hs_code);
    exp_t x;
    int   k;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", out_valid, 1);
      return;
    end
    if (sb.size() == 0) begin
      check("unexpected_result", 1, 0);
      return;
    end
    x = sb.pop_front();
    check("out_data", out_data, x.data);
    check("out_err", out_err, x.err);
    repeat (stall) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      {in_t1, in_t0} = 2'b01;
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_data", out_data, x.data);
      check("stall_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    in_valid  = hs_valid;
    {in_t1, in_t0} = hs_code;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("post_hs_out_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{10'b1001001001, 5, 8'd196, 1'b0, 0};  // 2,1,0,2,1
    tbl[1] = '{10'b1010101010, 5, 8'd242, 1'b0, 0};  // 2,2,2,2,2
    tbl[2] = '{10'b0000000000, 5, 8'd0,   1'b0, 0};  // 0,0,0,0,0
    tbl[3] = '{10'b0100110000, 3, 8'd0,   1'b1, 0};  // 1,0,bad
    tbl[4] = '{10'b0000000101, 5, 8'd4,   1'b0, 0};  // 0,0,0,1,1
    tbl[5] = '{10'b1100000000, 1, 8'd0,   1'b1, 0};  // bad first
    tbl[6] = '{10'b0101010111, 5, 8'd0,   1'b1, 0};  // bad last
    tbl[7] = '{10'b0101010101, 5, 8'd121, 1'b0, 3};  // 1,1,1,1,1 with gaps
    tbl[8] = '{10'b0110000110, 5, 8'd140, 1'b0, 1};  // 1,2,0,1,2

    reset = 1'b1;
    in_valid = 1'b0;
    in_t1 = 1'b0;
    in_t0 = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      run_word(tbl[i].codes, tbl[i].n, tbl[i].data, tbl[i].err, tbl[i].gap);
      take_result(0, 1'b0, 2'b00);
    end

    // Held result under back-pressure; trit offered in handshake cycle is ignored.
    run_word(10'b1001001001, 5, 8'd196, 1'b0, 0);
    take_result(3, 1'b1, 2'b10);
    run_word(10'b0000000001, 5, 8'd1, 1'b0, 0);
    take_result(0, 1'b0, 2'b00);

    // Unconsumed result is discarded by reset (asynchronous, mid-cycle).
    run_word(10'b1010101010, 5, 8'd242, 1'b0, 0);
    #2 reset = 1'b1;
    #1;
    sb.delete();
    check("rst_hold_out_valid", out_valid, 0);
    check("rst_hold_out_data", out_data, 0);
    check("rst_hold_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    // Partial word of three trits is discarded by reset.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      {in_t1, in_t0} = 2'b10;
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_partial_out_err", out_err, 0);
    check("rst_partial_out_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    run_word(10'b0100000000, 5, 8'd81, 1'b0, 0);
    take_result(0, 1'b0, 2'b00);

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
